// File: rtl/mem_dump_pkg.sv
// Shared types for the data-memory dump sequencer.
// State encoding, a reference beat layout for 32-bit sinks, and the default HALT encoding.
package mem_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_SUM  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Beat layout as seen by a 32-bit UART/trace sink.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    localparam logic [31:0] DEFAULT_HALT_INST = 32'd0;

endpackage

// File: rtl/mem_dump_engine.sv
// mem_dump_engine: on HALT or a manual request, stalls the core, walks the data memory
// from BASE_ADDR upward and streams (addr, data) beats over valid/ready.
// Optional feature macro: DUMP_CHECKSUM_EN -- appends one beat carrying the 32-bit
// modular sum of all dumped words, at address BASE_ADDR + DEPTH*STRIDE.
module mem_dump_engine
    import mem_dump_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,
    parameter int                STRIDE    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [31:0]       HALT_INST = DEFAULT_HALT_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_i,
    input  logic              dump_req_i,
    output logic              cpu_hold_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } dump_beat_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              halt_seen_reg, halt_seen_next;
    logic              halt_hit;
    logic              start;
    logic [ADDR_W-1:0] cur_addr;
    dump_beat_t        beat;
    logic              beat_valid;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0]       sum_reg, sum_next;
    logic [ADDR_W-1:0] sum_addr;
    // The checksum beat sits just past the last dumped word (wraps modulo 2^ADDR_W).
    assign sum_addr = BASE_ADDR + ADDR_W'(DEPTH) * ADDR_W'(STRIDE);
`endif

    // A parked core keeps presenting HALT; halt_seen makes that fire only once.
    assign halt_hit = (inst_i == HALT_INST) && !halt_seen_reg;
    assign start    = dump_req_i || halt_hit;
    // Word address wraps silently modulo 2^ADDR_W.
    assign cur_addr = BASE_ADDR + ADDR_W'(idx_reg) * ADDR_W'(STRIDE);

    assign cpu_hold_o   = busy_o;
    assign dump_valid_o = beat_valid;
    assign dump_addr_o  = beat.addr;
    assign dump_data_o  = beat.data;
    assign dump_last_o  = beat.last;

    // State and datapath registers; reset aborts any dump in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            data_reg      <= '0;
            halt_seen_reg <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            data_reg      <= data_next;
            halt_seen_reg <= halt_seen_next;
`ifdef DUMP_CHECKSUM_EN
            sum_reg       <= sum_next;
`endif
        end
    end

    // Next-state logic and all sequencer outputs.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        data_next      = data_reg;
        halt_seen_next = halt_seen_reg;
`ifdef DUMP_CHECKSUM_EN
        sum_next       = sum_reg;
`endif
        mem_rd_en_o    = 1'b0;
        mem_addr_o     = '0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        beat_valid     = 1'b0;
        beat           = '0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                done_o = (state_reg == ST_DONE);
                if (start) begin
                    state_next     = ST_READ;
                    idx_next       = '0;
                    halt_seen_next = halt_seen_reg || halt_hit;
`ifdef DUMP_CHECKSUM_EN
                    sum_next       = '0;
`endif
                end
            end
            ST_READ: begin
                busy_o      = 1'b1;
                mem_rd_en_o = 1'b1;
                mem_addr_o  = cur_addr;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                // Memory returns data exactly one cycle after the strobe.
                busy_o     = 1'b1;
                data_next  = mem_rdata_i;
                state_next = ST_OUT;
            end
            ST_OUT: begin
                busy_o     = 1'b1;
                beat_valid = 1'b1;
                beat.addr  = cur_addr;
                beat.data  = data_reg;
`ifdef DUMP_CHECKSUM_EN
                beat.last  = 1'b0;
`else
                beat.last  = (idx_reg == LAST_IDX);
`endif
                if (dump_ready_i) begin
`ifdef DUMP_CHECKSUM_EN
                    sum_next = sum_reg + 32'(data_reg);
`endif
                    if (idx_reg == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                        state_next = ST_SUM;
`else
                        state_next = ST_DONE;
`endif
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ST_READ;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_SUM: begin
                busy_o     = 1'b1;
                beat_valid = 1'b1;
                beat.addr  = sum_addr;
                beat.data  = DATA_W'(sum_reg);
                beat.last  = 1'b1;
                if (dump_ready_i) begin
                    state_next = ST_DONE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
